// File: rtl/scpu_run_ctrl.sv
// Run/halt/step sequencer for the single-cycle CPU: gates it with cpu_en and muxes reg_sel.
// Optional instruction trace outputs (trace_pc, trace_vld) are built when SCPU_RUN_TRACE_EN is defined.
module scpu_run_ctrl #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned STEP_W     = 16,
    parameter int unsigned CYC_LIMIT  = 1000,
    parameter bit          RUN_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_cnt,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   pc,
    input  logic              clr_cnt,
    input  logic [4:0]        reg_sel_sw,
    input  logic [4:0]        dbg_sel,
    input  logic              dbg_sel_vld,
    output logic              cpu_en,
    output logic [4:0]        reg_sel,
    output logic [1:0]        state,
    output logic              halted,
    output logic [PC_W-1:0]   cyc_cnt,
    output logic              limit_hit
`ifdef SCPU_RUN_TRACE_EN
    ,
    output logic [PC_W-1:0]   trace_pc,
    output logic              trace_vld
`endif
);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } run_state_t;

    localparam run_state_t        RST_STATE = RUN_ON_RST ? S_RUN : S_HALT;
    localparam bit                LIMIT_ON  = (CYC_LIMIT != 0);
    localparam logic [PC_W-1:0]   LIMIT_VAL = PC_W'(CYC_LIMIT);
    localparam logic [PC_W-1:0]   CYC_ONE   = PC_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    run_state_t        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              skip_q, skip_d;
    logic              bp_hit, limit_stop, step_ok, run_ok;

    assign bp_hit     = bp_en && (pc == bp_addr);
    assign limit_stop = LIMIT_ON && (cyc_cnt == LIMIT_VAL);
    assign step_ok    = step_req && !limit_hit;
    assign run_ok     = run_req && !limit_hit;
    assign state      = state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RST_STATE;
            step_q  <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            skip_q  <= skip_d;
        end
    end

    // skip lets the instruction sitting on a breakpoint execute once after resuming.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        skip_d  = skip_q;
        if (cpu_en) begin
            skip_d = 1'b0;
        end
        case (state_q)
            S_HALT, S_BREAK: begin
                if (step_ok) begin
                    state_d = S_STEP;
                    step_d  = (step_cnt == '0) ? STEP_ONE : step_cnt;
                    if (state_q == S_BREAK) begin
                        skip_d = 1'b1;
                    end
                end else if (run_ok) begin
                    state_d = S_RUN;
                    if (state_q == S_BREAK) begin
                        skip_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bp_hit && !skip_q) begin
                    state_d = S_BREAK;
                end
            end
            S_STEP: begin
                if (bp_hit && !skip_q) begin
                    state_d = S_BREAK;
                    step_d  = '0;
                end else if (cpu_en) begin
                    step_d = step_q - STEP_ONE;
                    if (step_q == STEP_ONE) begin
                        state_d = S_HALT;
                    end
                end
            end
        endcase
        if (limit_stop) begin
            state_d = S_HALT;
        end
        if (halt_req) begin
            state_d = S_HALT;
            skip_d  = 1'b0;
        end
    end

    always_comb begin
        cpu_en  = ((state_q == S_RUN) || (state_q == S_STEP))
                  && !(bp_hit && !skip_q) && !limit_stop;
        halted  = (state_q == S_HALT) || (state_q == S_BREAK);
        reg_sel = (halted && dbg_sel_vld) ? dbg_sel : reg_sel_sw;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_cnt   <= '0;
            limit_hit <= 1'b0;
        end else begin
            if (clr_cnt) begin
                cyc_cnt <= '0;
            end else if (cpu_en && (cyc_cnt != '1)) begin
                cyc_cnt <= cyc_cnt + CYC_ONE;
            end
            if (clr_cnt) begin
                limit_hit <= 1'b0;
            end else if (limit_stop) begin
                limit_hit <= 1'b1;
            end
        end
    end

`ifdef SCPU_RUN_TRACE_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trace_pc  <= '0;
            trace_vld <= 1'b0;
        end else begin
            trace_vld <= cpu_en;
            if (cpu_en) begin
                trace_pc <= pc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_scpu_run_ctrl.sv
// Self-checking bench for scpu_run_ctrl: directed sequences, a vector table and a randomized
// phase compared against a cycle-level behavioural model.
module tb_scpu_run_ctrl;

    localparam int LIMIT   = 1000;
    localparam int S_HALT  = 0;
    localparam int S_RUN   = 1;
    localparam int S_STEP  = 2;
    localparam int S_BREAK = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        run_req, halt_req, step_req, clr_cnt;
    logic [15:0] step_cnt;
    logic        bp_en;
    logic [31:0] bp_addr, pc;
    logic [4:0]  reg_sel_sw, dbg_sel;
    logic        dbg_sel_vld;
    logic        cpu_en;
    logic [4:0]  reg_sel;
    logic [1:0]  state;
    logic        halted;
    logic [31:0] cyc_cnt;
    logic        limit_hit;
`ifdef SCPU_RUN_TRACE_EN
    logic [31:0] trace_pc;
    logic        trace_vld;
`endif

    scpu_run_ctrl dut (
        .clk(clk), .rstn(rstn), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .step_cnt(step_cnt), .bp_en(bp_en), .bp_addr(bp_addr),
        .pc(pc), .clr_cnt(clr_cnt), .reg_sel_sw(reg_sel_sw), .dbg_sel(dbg_sel),
        .dbg_sel_vld(dbg_sel_vld), .cpu_en(cpu_en), .reg_sel(reg_sel), .state(state),
        .halted(halted), .cyc_cnt(cyc_cnt), .limit_hit(limit_hit)
`ifdef SCPU_RUN_TRACE_EN
        , .trace_pc(trace_pc), .trace_vld(trace_vld)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: current mode, instructions left in a step burst, resume-skip flag, counters.
    int          m_state;
    int          m_left;
    bit          m_skip;
    longint      m_cyc;
    bit          m_lim;
    logic [31:0] pc_mask = 32'hFF;

    typedef struct {
        logic        h, r, s;
        logic [15:0] cnt;
        logic        vld;
        logic [4:0]  dbg, sw;
        logic [1:0]  exp_state;
        logic        exp_en, exp_halted;
        logic [4:0]  exp_reg;
    } vec_t;
    vec_t vq[$];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_bp();
        return bp_en && (pc == bp_addr);
    endfunction

    function automatic bit model_en();
        if (!(m_state == S_RUN || m_state == S_STEP)) return 1'b0;
        if (model_bp() && !m_skip) return 1'b0;
        if (m_cyc == LIMIT) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state = S_RUN;
        m_left  = 0;
        m_skip  = 1'b0;
        m_cyc   = 0;
        m_lim   = 1'b0;
    endtask

    task automatic model_edge();
        bit en, at_limit, bp;
        int ns;
        en = model_en();
        at_limit = (m_cyc == LIMIT);
        bp = model_bp();
        ns = m_state;
        if (en) m_skip = 1'b0;
        if (m_state == S_HALT || m_state == S_BREAK) begin
            if (!m_lim && (step_req || run_req)) begin
                ns = step_req ? S_STEP : S_RUN;
                if (step_req) m_left = (step_cnt == 0) ? 1 : int'(step_cnt);
                if (m_state == S_BREAK) m_skip = 1'b1;
            end
        end else if (bp && !m_skip && !en) begin
            ns = S_BREAK;
        end else if (m_state == S_STEP && en) begin
            m_left--;
            if (m_left == 0) ns = S_HALT;
        end
        if (at_limit) ns = S_HALT;
        if (halt_req) begin
            ns = S_HALT;
            m_skip = 1'b0;
        end
        m_state = ns;
        if (clr_cnt) m_cyc = 0;
        else if (en && m_cyc < 64'hFFFF_FFFF) m_cyc++;
        if (clr_cnt) m_lim = 1'b0;
        else if (at_limit) m_lim = 1'b1;
    endtask

    task automatic check_model(input int n);
        bit h;
        h = (m_state == S_HALT) || (m_state == S_BREAK);
        check_output($sformatf("rnd%0d.state", n), 32'(state), 32'(m_state));
        check_output($sformatf("rnd%0d.cpu_en", n), 32'(cpu_en), 32'(model_en()));
        check_output($sformatf("rnd%0d.halted", n), 32'(halted), 32'(h));
        check_output($sformatf("rnd%0d.reg_sel", n), 32'(reg_sel),
                     32'((h && dbg_sel_vld) ? dbg_sel : reg_sel_sw));
        check_output($sformatf("rnd%0d.cyc_cnt", n), cyc_cnt, 32'(m_cyc));
        check_output($sformatf("rnd%0d.limit_hit", n), 32'(limit_hit), 32'(m_lim));
    endtask

    // Advance one clock edge; the bench plays the CPU by moving pc on every enabled edge.
    task automatic step_cycle();
        bit en;
        logic [31:0] pc_then;
        en = model_en();
        pc_then = pc;
        model_edge();
        @(posedge clk);
        #1;
`ifdef SCPU_RUN_TRACE_EN
        check_output("trace_vld", 32'(trace_vld), 32'(en));
        if (en) check_output("trace_pc", trace_pc, pc_then);
`endif
        halt_req = 1'b0;
        run_req  = 1'b0;
        step_req = 1'b0;
        clr_cnt  = 1'b0;
        if (en) pc = (pc + 32'd4) & pc_mask;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        {run_req, halt_req, step_req, clr_cnt, bp_en, dbg_sel_vld} = '0;
        step_cnt = '0; bp_addr = '0; pc = '0; reg_sel_sw = '0; dbg_sel = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic add_vec(input logic h, r, s, input logic [15:0] cnt, input logic vld,
                           input logic [4:0] dbg, sw, input logic [1:0] st, input logic en,
                           input logic [4:0] rs);
        vec_t v;
        v = '{h, r, s, cnt, vld, dbg, sw, st, en, (st == 2'd0) || (st == 2'd3), rs};
        vq.push_back(v);
    endtask

    task automatic apply_stimulus(input int i);
        halt_req = vq[i].h; run_req = vq[i].r; step_req = vq[i].s;
        step_cnt = vq[i].cnt; dbg_sel_vld = vq[i].vld; dbg_sel = vq[i].dbg;
        reg_sel_sw = vq[i].sw;
        #1;
        check_output($sformatf("vec%0d.state", i), 32'(state), 32'(vq[i].exp_state));
        check_output($sformatf("vec%0d.cpu_en", i), 32'(cpu_en), 32'(vq[i].exp_en));
        check_output($sformatf("vec%0d.halted", i), 32'(halted), 32'(vq[i].exp_halted));
        check_output($sformatf("vec%0d.reg_sel", i), 32'(reg_sel), 32'(vq[i].exp_reg));
        step_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Vector table: {halt, run, step, step_cnt, dbg_vld, dbg_sel, sw} -> {state, cpu_en, reg_sel}
        add_vec(1, 1, 1, 16'd0, 1, 5'd7, 5'd3, 2'd1, 1, 5'd3);
        add_vec(0, 0, 0, 16'd0, 1, 5'd7, 5'd3, 2'd0, 0, 5'd7);
        add_vec(0, 0, 0, 16'd0, 0, 5'd7, 5'd3, 2'd0, 0, 5'd3);
        add_vec(0, 0, 1, 16'd3, 1, 5'd9, 5'd4, 2'd0, 0, 5'd9);
        add_vec(0, 0, 0, 16'd0, 1, 5'd9, 5'd4, 2'd2, 1, 5'd4);
        add_vec(0, 0, 0, 16'd0, 1, 5'd9, 5'd4, 2'd2, 1, 5'd4);
        add_vec(0, 0, 0, 16'd0, 1, 5'd9, 5'd4, 2'd2, 1, 5'd4);
        add_vec(0, 0, 0, 16'd0, 1, 5'd9, 5'd4, 2'd0, 0, 5'd9);
        add_vec(0, 0, 1, 16'd0, 1, 5'd9, 5'd4, 2'd0, 0, 5'd9);
        add_vec(0, 0, 0, 16'd0, 1, 5'd9, 5'd4, 2'd2, 1, 5'd4);
        add_vec(0, 0, 0, 16'd0, 1, 5'd9, 5'd4, 2'd0, 0, 5'd9);
        add_vec(0, 0, 1, 16'd5, 1, 5'd9, 5'd4, 2'd0, 0, 5'd9);
        add_vec(0, 0, 0, 16'd0, 1, 5'd9, 5'd4, 2'd2, 1, 5'd4);
        add_vec(1, 0, 0, 16'd0, 1, 5'd9, 5'd4, 2'd2, 1, 5'd4);
        add_vec(0, 0, 0, 16'd0, 1, 5'd9, 5'd4, 2'd0, 0, 5'd9);
        add_vec(0, 1, 0, 16'd0, 1, 5'd9, 5'd4, 2'd0, 0, 5'd9);
        add_vec(0, 0, 0, 16'd0, 1, 5'd9, 5'd4, 2'd1, 1, 5'd4);

        apply_reset();

        // Free run from reset up to the cycle limit.
        for (int k = 0; k < LIMIT; k++) begin
            #1;
            if (k < 5) begin
                check_output($sformatf("boot%0d.state", k), 32'(state), 32'(S_RUN));
                check_output($sformatf("boot%0d.cpu_en", k), 32'(cpu_en), 32'd1);
                check_output($sformatf("boot%0d.cyc_cnt", k), cyc_cnt, 32'(k));
            end
            step_cycle();
        end
        #1;
        check_output("limit.cyc_cnt", cyc_cnt, 32'd1000);
        check_output("limit.cpu_en", 32'(cpu_en), 32'd0);
        check_output("limit.state_pre", 32'(state), 32'(S_RUN));
        check_output("limit.hit_pre", 32'(limit_hit), 32'd0);
        step_cycle();
        #1;
        check_output("limit.state", 32'(state), 32'(S_HALT));
        check_output("limit.hit", 32'(limit_hit), 32'd1);
        check_output("limit.cyc_hold", cyc_cnt, 32'd1000);
        run_req = 1'b1;
        step_cycle();
        #1;
        check_output("limit.run_ignored", 32'(state), 32'(S_HALT));
        clr_cnt = 1'b1;
        step_cycle();
        #1;
        check_output("clr.cyc_cnt", cyc_cnt, 32'd0);
        check_output("clr.limit_hit", 32'(limit_hit), 32'd0);
        run_req = 1'b1;
        #1;
        check_output("clr.cpu_en_halt", 32'(cpu_en), 32'd0);
        step_cycle();
        #1;
        check_output("rerun.state", 32'(state), 32'(S_RUN));
        check_output("rerun.cpu_en", 32'(cpu_en), 32'd1);
        step_cycle();
        #1;
        check_output("rerun.cyc_cnt", cyc_cnt, 32'd1);

        for (int i = 0; i < vq.size(); i++) apply_stimulus(i);

        // Breakpoint at 0x48, then resume past it.
        dbg_sel_vld = 1'b0;
        pc = 32'h40; bp_en = 1'b1; bp_addr = 32'h48;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_output($sformatf("bp.pre%0d.cpu_en", k), 32'(cpu_en), 32'd1);
            step_cycle();
        end
        #1;
        check_output("bp.hit.pc", pc, 32'h48);
        check_output("bp.hit.cpu_en", 32'(cpu_en), 32'd0);
        step_cycle();
        #1;
        check_output("bp.state", 32'(state), 32'(S_BREAK));
        check_output("bp.halted", 32'(halted), 32'd1);
        check_output("bp.cpu_en", 32'(cpu_en), 32'd0);
        run_req = 1'b1;
        step_cycle();
        #1;
        check_output("bp.resume.state", 32'(state), 32'(S_RUN));
        check_output("bp.resume.cpu_en", 32'(cpu_en), 32'd1);
        step_cycle();
        for (int k = 0; k < 3; k++) begin
            #1;
            check_output($sformatf("bp.post%0d.state", k), 32'(state), 32'(S_RUN));
            check_output($sformatf("bp.post%0d.cpu_en", k), 32'(cpu_en), 32'd1);
            step_cycle();
        end
        bp_en = 1'b0;

        // Asynchronous reset in the middle of a 5-instruction step burst.
        halt_req = 1'b1;
        step_cycle();
        step_req = 1'b1; step_cnt = 16'd5;
        step_cycle();
        #1;
        check_output("arst.step_state", 32'(state), 32'(S_STEP));
        step_cycle();
        #3;
        rstn = 1'b0;
        #1;
        model_reset();
        check_output("arst.state", 32'(state), 32'(S_RUN));
        check_output("arst.cyc_cnt", cyc_cnt, 32'd0);
        check_output("arst.cpu_en", 32'(cpu_en), 32'd1);
        @(posedge clk);
        #1;
        check_output("arst.held_cyc", cyc_cnt, 32'd0);
        rstn = 1'b1;
        #1;
        step_cycle();
        #1;
        check_output("arst.after_cyc", cyc_cnt, 32'd1);

        // Randomized traffic against the model.
        apply_reset();
        pc_mask = 32'h3F;
        for (int n = 0; n < 4000; n++) begin
            halt_req = ($urandom_range(0, 15) == 0);
            run_req  = ($urandom_range(0, 7) == 0);
            step_req = ($urandom_range(0, 7) == 0);
            step_cnt = 16'($urandom_range(0, 4));
            clr_cnt  = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 31) == 0) bp_en = ~bp_en;
            if ($urandom_range(0, 63) == 0) bp_addr = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 31) == 0) pc = 32'($urandom_range(0, 15)) << 2;
            dbg_sel_vld = 1'($urandom_range(0, 1));
            dbg_sel     = 5'($urandom_range(0, 31));
            reg_sel_sw  = 5'($urandom_range(0, 31));
            #1;
            check_model(n);
            step_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
